// File: rtl/elevator_scheduler.sv
// Purpose: SCAN scheduler and motion sequencer for a 4-floor car; latches calls and drives motor/door outputs.
// Latency: a call latches one edge after it is sampled; IDLE acts one edge later; each floor takes TRAVEL_CYCLES cycles.
// Backpressure: none; calls are level/pulse inputs sampled every cycle, and a call for the stopped floor extends the dwell.
module elevator_scheduler #(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [1:0] floor,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic       dir_up,
    output logic [3:0] pending,
    output logic       busy
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    floor_q, floor_d;
    logic          dir_up_q, dir_up_d;
    logic [3:0]    pending_q, pending_d;
    logic [TW-1:0] travel_cnt_q, travel_cnt_d;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;

    logic [3:0]    req_all;
    logic [3:0]    clr;
    logic [1:0]    next_floor;
    logic          above;
    logic          below;
    logic          ahead_after_step;

    // Floors strictly above f (bits f+1..3).
    function automatic logic [3:0] above_mask(input logic [1:0] f);
        logic [3:0] m;
        m = 4'b1110 << f;
        return m;
    endfunction

    // Floors strictly below f (bits 0..f-1).
    function automatic logic [3:0] below_mask(input logic [1:0] f);
        logic [3:0] m;
        m = ~(4'b1111 << f);
        return m;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] f);
        logic [3:0] m;
        m = 4'b0001 << f;
        return m;
    endfunction

    // Next-state, SCAN decision, counters and call latching.
    always_comb begin
        state_d          = state_q;
        floor_d          = floor_q;
        dir_up_d         = dir_up_q;
        travel_cnt_d     = travel_cnt_q;
        dwell_cnt_d      = dwell_cnt_q;
        clr              = 4'b0000;
        req_all          = pending_q | req;
        above            = |(pending_q & above_mask(floor_q));
        below            = |(pending_q & below_mask(floor_q));
        // Step gated at the shaft ends even though entry conditions already prevent it.
        next_floor       = floor_q;
        if (dir_up_q && floor_q != 2'd3) begin
            next_floor = floor_q + 2'd1;
        end else if (!dir_up_q && floor_q != 2'd0) begin
            next_floor = floor_q - 2'd1;
        end
        // Includes this cycle's calls so an arrival-cycle call still counts.
        ahead_after_step = dir_up_q ? |(req_all & above_mask(next_floor))
                                    : |(req_all & below_mask(next_floor));

        case (state_q)
            ST_IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d     = ST_DOOR;
                    clr         = onehot(floor_q);
                    dwell_cnt_d = '0;
                end else if (above && (dir_up_q || !below)) begin
                    state_d      = ST_MOVE;
                    dir_up_d     = 1'b1;
                    travel_cnt_d = '0;
                end else if (below) begin
                    state_d      = ST_MOVE;
                    dir_up_d     = 1'b0;
                    travel_cnt_d = '0;
                end
            end
            ST_MOVE: begin
                if (travel_cnt_q == TRAVEL_LAST) begin
                    travel_cnt_d = '0;
                    floor_d      = next_floor;
                    if (req_all[next_floor]) begin
                        state_d     = ST_DOOR;
                        clr         = onehot(next_floor);
                        dwell_cnt_d = '0;
                    end else if (!ahead_after_step) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    travel_cnt_d = travel_cnt_q + 1'b1;
                end
            end
            ST_DOOR: begin
                // The stopped floor is held clear; pressing it restarts the dwell.
                clr = onehot(floor_q);
                if (req[floor_q]) begin
                    dwell_cnt_d = '0;
                end else if (dwell_cnt_q == DOOR_LAST) begin
                    state_d     = ST_IDLE;
                    dwell_cnt_d = '0;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pending_d = req_all & ~clr;
    end

    // State registers; reset aborts any motion and drops all latched calls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            floor_q      <= 2'd0;
            dir_up_q     <= 1'b1;
            pending_q    <= 4'b0000;
            travel_cnt_q <= '0;
            dwell_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            dir_up_q     <= dir_up_d;
            pending_q    <= pending_d;
            travel_cnt_q <= travel_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
        end
    end

    assign floor      = floor_q;
    assign dir_up     = dir_up_q;
    assign pending    = pending_q;
    assign motor_up   = (state_q == ST_MOVE) & dir_up_q;
    assign motor_down = (state_q == ST_MOVE) & ~dir_up_q;
    assign door_open  = (state_q == ST_DOOR);
    assign busy       = (state_q != ST_IDLE) | (|pending_q);

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request scheduler and motion sequencer for the 4-floor elevator car. It latches floor-call buttons into a pending set and picks the next stop with a SCAN policy: keep travelling in the current direction while calls remain ahead, then reverse. It times floor-to-floor travel and door dwell, and drives the motor and door outputs. It replaces ad-hoc next-floor logic and sits between the call-button inputs and the car's motor/door actuators.

## Interface
- TRAVEL_CYCLES, default 4: clock cycles spent in MOVE per floor traversed (≥1).
- DOOR_CYCLES, default 3: cycles door_open stays high per stop (≥1).

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  4  call buttons, bit i = floor i, level or pulse; sampled every cycle.
- floor  out  2  current car floor.
- motor_up  out  1  high while the car moves up.
- motor_down  out  1  high while the car moves down.
- door_open  out  1  high while the car dwells at a stop.
- dir_up  out  1  current sweep direction (1 = up).
- pending  out  4  latched, unserved calls.
- busy  out  1  high when state is not IDLE or pending ≠ 0.

## Operation
- States: IDLE, MOVE, DOOR. All outputs are registered or decoded from registered state (Moore).
- motor_up = (state==MOVE) & dir_up. motor_down = (state==MOVE) & ~dir_up. door_open = (state==DOOR). The motor and door are never active together.
- Latching: pending <= (pending | req) & ~clr. clr is onehot(floor) in any cycle where state==DOOR, or where a transition into DOOR clears that floor.
- Calls for the current floor during DOOR are not latched. They reload the dwell counter, extending the stop.
- "above" = any pending bit > floor. "below" = any pending bit < floor.
- IDLE, evaluated on registered pending:
  - pending[floor] → DOOR; clear that bit.
  - else if above and (dir_up or not below) → MOVE, dir_up=1.
  - else if below → MOVE, dir_up=0.
  - else stay in IDLE; dir_up holds.
- MOVE: a travel counter runs 0..TRAVEL_CYCLES-1. On the terminal count, floor steps ±1 and the counter resets. Using the new floor f':
  - pending[f'] → DOOR; clear bit f' at the same edge.
  - else calls remain beyond f' in dir_up → stay in MOVE.
  - else → IDLE.
- DOOR: a dwell counter runs 0..DOOR_CYCLES-1. At the terminal count → IDLE.
- Reversal happens only through IDLE. This costs one IDLE cycle between a stop and the opposite sweep.
- Bounds: the car never moves up from floor 3 or down from floor 0. The MOVE entry conditions guarantee this; the RTL also gates it explicitly.

## Timing
- Reset (async assert, sync release) sets:
  - state=IDLE, floor=0, dir_up=1, pending=0, counters=0.
  - all motor/door outputs 0, busy=0.
- reset_n asserted mid-MOVE or mid-DOOR aborts immediately to the reset values. Pending calls are lost.
- A call asserted in cycle t appears in pending after edge t+1. IDLE acts on it at edge t+2.
- Travel: each floor costs exactly TRAVEL_CYCLES cycles with the motor high. The floor output changes on the same edge the counter wraps.
- Arrival at a called floor: the motor drops and door_open rises on the same edge. door_open stays high for DOOR_CYCLES cycles, longer if extended.
- Simultaneous events:
  - A call for the floor being arrived at in the arrival cycle counts as a stop.
  - Calls for other floors latch normally during MOVE/DOOR and are served per SCAN.
- Calls during MOVE for floors already passed wait for the reverse sweep.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with req=4'b1111 → floor=0, pending=0, all outputs 0. Release → pending=1111 next cycle. Door opens at floor 0 first, with no motor activity.
- Single call: idle at 0, pulse req=0100 for 1 cycle → motor_up high 8 cycles, floor=1 after 4, floor=2 after 8. Then door_open high 3 cycles, then IDLE, busy=0.
- SCAN order: at floor 0, req=1010 together → stops at 1 then 3, never moving down in between. pending goes 1010→1000→0000.
- Reversal: at floor 2 in DOOR, latch req=1001 → serve floor 3 first (dir_up=1). Then one IDLE cycle, dir_up=0, motor_down, stop at 0.
- Door extend: in DOOR at floor 2, hold req=0100 for 5 cycles → door_open stays high 5+3 cycles and pending[2] never sets.
- Reset mid-move: assert reset_n=0 while motor_up=1 between floors 1 and 2 → outputs clear asynchronously, floor=0, pending=0.
